seg_led_ascii_capture: RTL and testbench
========================================

// Module: seg_led_ascii_capture
// PURPOSE
//  Receive side of the 6-digit multiplexed 7-segment bus (active-low seg_sel / seg_led).
//  Samples the scanned bus, filters scan skew, decodes each digit's segment pattern back to ASCII.
//  Publishes all six characters atomically once per complete scan frame.
//  Used for loopback self-test of the display path and to tap an external scanned display.
// PARAMETERS
//  SYNC_STAGES    2      synchronizer depth on seg_sel_in/seg_led_in (>=2)
//  STABLE_CYCLES  64     clk cycles {sel,led} must hold unchanged before capture (>=2; exceeds 32-clk sel/led skew)
//  BLANK_TIMEOUT  65536  consecutive all-deselected clk cycles before display declared blank
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous reset, active-high
//  seg_sel_in    in   6  digit select, active-low, bit0 = rightmost digit (char0)
//  seg_led_in    in   8  segments {h,g,f,e,d,c,b,a}, active-low
//  char0..char5  out  8  published ASCII per digit
//  frame_valid   out  1  1-clk pulse when char0..5 update
//  decode_err    out  1  error status of the last published frame
//  blank         out  1  level: no digit selected for BLANK_TIMEOUT cycles
// BEHAVIOUR
//  Reset (async, any time): chars=8'h00, frame_valid=0, decode_err=0, blank=1. Sync flops load 1s (inactive).
//   Shadow, seen[5:0], err_pend, stable/idle counters cleared. Partial frame discarded.
//  Sync: both buses pass SYNC_STAGES flops; all logic below uses synced values.
//  Stability: stable_cnt clears when synced {sel,led} differs from the previous cycle; otherwise increments, saturating.
//   Reaching STABLE_CYCLES-1 gives exactly one cap_stb; no further strobe until the input changes.
//  On cap_stb:
//   - sel exactly one bit low (index i): shadow[i] <= decode(led[6:0]); seen[i] <= 1.
//     An unknown pattern also sets err_pend.
//   - sel == 6'h3F: no action.
//   - two or more bits low: no capture; err_pend <= 1.
//   - Re-capturing an already-seen digit overwrites shadow[i] (last value wins).
//  Decode (led[6:0] -> ASCII; h ignored):
//   7F->00, 40->'0', 79->'1', 24->'2', 30->'3', 19->'4', 12->'5', 02->'6', 78->'7', 00->'8', 10->'9', 0E->'F'.
//   Any other pattern -> '?' (8'h3F) plus error.
//  Publish: the cycle after seen becomes 6'h3F:
//   chars <= shadow; frame_valid=1 for 1 clk; decode_err <= err_pend; seen, err_pend cleared.
//   If cap_stb coincides with the publish cycle, clear is applied first, then the new bit sets.
//   That capture counts toward the next frame.
//  Latency: input stable -> shadow write = SYNC_STAGES+STABLE_CYCLES clk; 6th capture -> frame_valid = +1 clk.
//  Blank: idle_cnt counts cycles with synced sel==6'h3F and clears otherwise.
//   At BLANK_TIMEOUT: chars <= 8'h00, blank <= 1, seen/shadow/err_pend cleared. No frame_valid pulse.
//   idle_cnt saturates, so there is a single event. blank <= 0 on the next valid single-digit capture.
//  decode_err and chars hold between publishes; frame_valid is never asserted on two consecutive cycles.
// STRUCTURE
//  Shared include seg_ascii_defs.vh: SEG_* active-low pattern constants (blank, 0-9, F) and ASCII_BLANK/ASCII_UNK.
//   It is also used by the display driver, so encode and decode tables cannot diverge.
//  Sub-module seg7_ascii_decode (combinational): led[6:0] -> {err, ascii[7:0]}.
//  Top holds synchronizers, stability and idle counters, shadow/seen registers, and publish logic.
// TESTING
//  1. Drive digits 0..5 = '1','2','3','4','5','6' patterns, 40000 clk each, sel/led skewed 32 clk
//     -> one frame_valid; chars 0x31..0x36; decode_err=0.
//  2. Digit 3 led=8'hFF, others '0' -> char3=8'h00, rest 0x30, decode_err=0.
//     Digit 2 led=8'h8E -> char2='F', decode_err=0.
//  3. Digit 4 led=8'h55 (unknown) -> char4=8'h3F, decode_err=1.
//     Next clean frame -> decode_err=0.
//  4. Glitch: sel toggles every 10 clk for 500 clk -> no capture, no frame_valid.
//     sel=6'b111100 held 200 clk -> err flagged on the following publish.
//  5. Complete a frame of '8'; then sel=6'h3F for 65536 clk
//     -> blank=1, chars=0x00, no frame_valid pulse.
//     Next digit capture -> blank=0.
//  6. Assert rst after 4 of 6 digits captured, then release and scan a full '9' frame
//     -> first frame_valid only after all 6 new captures; chars=0x39.

Source files
------------

// File: rtl/seg_led_ascii_capture_pkg.sv
// Shared segment/ASCII tables for the 7-segment display path.
// The display driver encodes from the same constants, so encode and decode cannot diverge.
package seg_led_ascii_capture_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_F     = 7'h0E;

  localparam logic [7:0] ASCII_BLANK = 8'h00;
  localparam logic [7:0] ASCII_UNK   = 8'h3F;

  typedef struct packed {
    logic       err;
    logic [7:0] ascii;
  } seg_dec_t;

  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t r;
    r.err = 1'b0;
    unique case (seg)
      SEG_BLANK: r.ascii = ASCII_BLANK;
      SEG_0:     r.ascii = 8'h30;
      SEG_1:     r.ascii = 8'h31;
      SEG_2:     r.ascii = 8'h32;
      SEG_3:     r.ascii = 8'h33;
      SEG_4:     r.ascii = 8'h34;
      SEG_5:     r.ascii = 8'h35;
      SEG_6:     r.ascii = 8'h36;
      SEG_7:     r.ascii = 8'h37;
      SEG_8:     r.ascii = 8'h38;
      SEG_9:     r.ascii = 8'h39;
      SEG_F:     r.ascii = 8'h46;
      default: begin
        r.ascii = ASCII_UNK;
        r.err   = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_ascii_decode.sv
// Combinational 7-segment (active-low) to ASCII decoder; flags unknown patterns.
module seg7_ascii_decode
  import seg_led_ascii_capture_pkg::*;
(
  input  logic [6:0] led,
  output logic       err,
  output logic [7:0] ascii
);

  seg_dec_t dec;

  assign dec   = seg_decode(led);
  assign err   = dec.err;
  assign ascii = dec.ascii;

endmodule

// File: rtl/seg_led_ascii_capture.sv
// Receive side of a 6-digit multiplexed 7-segment bus: filters scan skew, decodes each
// digit back to ASCII and publishes all six characters atomically once per full frame.
module seg_led_ascii_capture
  import seg_led_ascii_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned BLANK_TIMEOUT = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] seg_sel_in,
  input  logic [7:0] seg_led_in,
  output logic [7:0] char0,
  output logic [7:0] char1,
  output logic [7:0] char2,
  output logic [7:0] char3,
  output logic [7:0] char4,
  output logic [7:0] char5,
  output logic       frame_valid,
  output logic       decode_err,
  output logic       blank
);

  localparam int unsigned StableW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned IdleW   = $clog2(BLANK_TIMEOUT + 1);
  localparam logic [StableW-1:0] StableMax = StableW'(STABLE_CYCLES - 1);
  localparam logic [StableW-1:0] StableArm = StableW'(STABLE_CYCLES - 2);
  localparam logic [IdleW-1:0]   IdleMax   = IdleW'(BLANK_TIMEOUT);
  localparam logic [IdleW-1:0]   IdleArm   = IdleW'(BLANK_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0][5:0] sel_pipe_q;
  logic [SYNC_STAGES-1:0][7:0] led_pipe_q;
  logic [5:0]                  sel;
  logic [7:0]                  led;
  logic [13:0]                 prev_q;
  logic [StableW-1:0]          stable_cnt_q, stable_cnt_d;
  logic [IdleW-1:0]            idle_cnt_q, idle_cnt_d;
  logic                        changed, cap_stb, blank_evt, publish;

  logic [NUM_DIGITS-1:0][7:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][7:0] chars_q, chars_d;
  logic [NUM_DIGITS-1:0]      seen_q, seen_d;
  logic                       err_pend_q, err_pend_d;
  logic                       frame_valid_q, frame_valid_d;
  logic                       decode_err_q, decode_err_d;
  logic                       blank_q, blank_d;

  logic [2:0] n_low;
  logic [2:0] dig_idx;
  logic       dec_err;
  logic [7:0] dec_ascii;

  // Synchronizers reset to all-ones, i.e. nothing selected and all segments off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_pipe_q <= '1;
      led_pipe_q <= '1;
      prev_q     <= '1;
    end else begin
      sel_pipe_q <= {sel_pipe_q[SYNC_STAGES-2:0], seg_sel_in};
      led_pipe_q <= {led_pipe_q[SYNC_STAGES-2:0], seg_led_in};
      prev_q     <= {sel, led};
    end
  end

  assign sel     = sel_pipe_q[SYNC_STAGES-1];
  assign led     = led_pipe_q[SYNC_STAGES-1];
  assign changed = ({sel, led} != prev_q);

  // Strobe fires on the single transition into StableMax, so a held input captures once
  always_comb begin
    stable_cnt_d = stable_cnt_q;
    if (changed) begin
      stable_cnt_d = '0;
    end else if (stable_cnt_q != StableMax) begin
      stable_cnt_d = stable_cnt_q + 1'b1;
    end
  end

  assign cap_stb = !changed && (stable_cnt_q == StableArm);

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (sel != 6'h3F) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IdleMax) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  assign blank_evt = (sel == 6'h3F) && (idle_cnt_q == IdleArm);

  always_comb begin
    n_low   = '0;
    dig_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sel[i]) begin
        n_low   = n_low + 3'd1;
        dig_idx = 3'(i);
      end
    end
  end

  seg7_ascii_decode u_decode (
    .led   (led[6:0]),
    .err   (dec_err),
    .ascii (dec_ascii)
  );

  assign publish = (seen_q == '1);

  always_comb begin
    shadow_d      = shadow_q;
    chars_d       = chars_q;
    seen_d        = seen_q;
    err_pend_d    = err_pend_q;
    frame_valid_d = 1'b0;
    decode_err_d  = decode_err_q;
    blank_d       = blank_q;
    if (blank_evt) begin
      chars_d    = '0;
      shadow_d   = '0;
      seen_d     = '0;
      err_pend_d = 1'b0;
      blank_d    = 1'b1;
    end else begin
      if (publish) begin
        chars_d       = shadow_q;
        frame_valid_d = 1'b1;
        decode_err_d  = err_pend_q;
        seen_d        = '0;
        err_pend_d    = 1'b0;
      end
      // Applied after the publish clear so a coincident capture belongs to the next frame
      if (cap_stb) begin
        if (n_low == 3'd1) begin
          shadow_d[dig_idx] = dec_ascii;
          seen_d[dig_idx]   = 1'b1;
          blank_d           = 1'b0;
          if (dec_err) begin
            err_pend_d = 1'b1;
          end
        end else if (n_low > 3'd1) begin
          err_pend_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_cnt_q  <= '0;
      idle_cnt_q    <= '0;
      shadow_q      <= '0;
      chars_q       <= '0;
      seen_q        <= '0;
      err_pend_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      decode_err_q  <= 1'b0;
      blank_q       <= 1'b1;
    end else begin
      stable_cnt_q  <= stable_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      shadow_q      <= shadow_d;
      chars_q       <= chars_d;
      seen_q        <= seen_d;
      err_pend_q    <= err_pend_d;
      frame_valid_q <= frame_valid_d;
      decode_err_q  <= decode_err_d;
      blank_q       <= blank_d;
    end
  end

  assign char0       = chars_q[0];
  assign char1       = chars_q[1];
  assign char2       = chars_q[2];
  assign char3       = chars_q[3];
  assign char4       = chars_q[4];
  assign char5       = chars_q[5];
  assign frame_valid = frame_valid_q;
  assign decode_err  = decode_err_q;
  assign blank       = blank_q;

endmodule

// File: tb/tb_seg_led_ascii_capture.sv
// Directed bench for seg_led_ascii_capture: scans frames over a skewed bus and checks
// published characters, error status, blanking and reset behaviour.
module tb_seg_led_ascii_capture;

  localparam int unsigned BlankTo = 1024;
  localparam int          Hold    = 120;

  localparam logic [7:0] P0 = 8'hC0, P1 = 8'hF9, P2 = 8'hA4, P3 = 8'hB0, P4 = 8'h99;
  localparam logic [7:0] P5 = 8'h92, P6 = 8'h82, P8 = 8'h80, P9 = 8'h90, PF = 8'h8E;
  localparam logic [7:0] PBL = 8'hFF;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] sel;
  logic [7:0] led;
  logic [7:0] c0, c1, c2, c3, c4, c5;
  logic       fv, derr, blank;

  int n_cmp  = 0;
  int n_fail = 0;
  int fv_cnt = 0;
  int fv_dbl = 0;
  int fv0;
  logic fv_prev = 1'b0;

  always #5 clk = ~clk;

  seg_led_ascii_capture #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (64),
    .BLANK_TIMEOUT (BlankTo)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_sel_in  (sel),
    .seg_led_in  (led),
    .char0       (c0),
    .char1       (c1),
    .char2       (c2),
    .char3       (c3),
    .char4       (c4),
    .char5       (c5),
    .frame_valid (fv),
    .decode_err  (derr),
    .blank       (blank)
  );

  always @(posedge clk) begin
    if (fv === 1'b1) fv_cnt <= fv_cnt + 1;
    if (fv === 1'b1 && fv_prev === 1'b1) fv_dbl <= fv_dbl + 1;
    fv_prev <= fv;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // exp packs {char5, ..., char0}
  task automatic check_chars(input string tag, input logic [47:0] exp);
    check8({tag, ".c0"}, c0, exp[7:0]);
    check8({tag, ".c1"}, c1, exp[15:8]);
    check8({tag, ".c2"}, c2, exp[23:16]);
    check8({tag, ".c3"}, c3, exp[31:24]);
    check8({tag, ".c4"}, c4, exp[39:32]);
    check8({tag, ".c5"}, c5, exp[47:40]);
  endtask

  // Select moves first, segments follow 32 clk later to emulate driver skew
  task automatic drive_digit(input int idx, input logic [7:0] pat, input int hold);
    logic [5:0] one;
    one = 6'b000001;
    sel = ~(one << idx);
    tick(32);
    led = pat;
    tick(hold);
  endtask

  // pats packs {digit5, ..., digit0}
  task automatic scan(input logic [47:0] pats);
    for (int i = 0; i < 6; i++) drive_digit(i, pats[i*8 +: 8], Hold);
  endtask

  initial begin
    rst = 1'b1;
    sel = 6'h3F;
    led = 8'hFF;
    tick(3);
    check_chars("reset", 48'h0);
    check1("reset.fv", fv, 1'b0);
    check1("reset.derr", derr, 1'b0);
    check1("reset.blank", blank, 1'b1);
    rst = 1'b0;
    tick(5);

    // 1: digits '1'..'6'
    fv0 = fv_cnt;
    scan({P6, P5, P4, P3, P2, P1});
    check_int("t1.fv_count", fv_cnt, fv0 + 1);
    check_chars("t1", 48'h363534333231);
    check1("t1.derr", derr, 1'b0);
    check1("t1.blank", blank, 1'b0);

    // 2: blank digit decodes to 00, F decodes to 'F'
    scan({P0, P0, PBL, P0, P0, P0});
    check_chars("t2a", 48'h303000303030);
    check1("t2a.derr", derr, 1'b0);
    scan({P0, P0, P0, PF, P0, P0});
    check_chars("t2b", 48'h303030463030);
    check1("t2b.derr", derr, 1'b0);

    // 3: unknown pattern, then a clean frame clears the error
    fv0 = fv_cnt;
    scan({P0, 8'h55, P0, P0, P0, P0});
    check_int("t3a.fv_count", fv_cnt, fv0 + 1);
    check_chars("t3a", 48'h303F30303030);
    check1("t3a.derr", derr, 1'b1);
    scan({P6, P5, P4, P3, P2, P1});
    check1("t3b.derr", derr, 1'b0);
    check_chars("t3b", 48'h363534333231);

    // 4: glitching select, then a multi-select error
    fv0 = fv_cnt;
    led = P1;
    for (int k = 0; k < 50; k++) begin
      sel = (k % 2 == 0) ? 6'h3E : 6'h3D;
      tick(10);
    end
    check_int("t4.glitch_fv", fv_cnt, fv0);
    sel = 6'b111100;
    tick(200);
    check_int("t4.multi_fv", fv_cnt, fv0);
    check1("t4.derr_held", derr, 1'b0);
    scan({P6, P5, P4, P3, P2, P1});
    check_int("t4.fv_count", fv_cnt, fv0 + 1);
    check1("t4.derr", derr, 1'b1);
    check_chars("t4", 48'h363534333231);

    // 5: '8' frame then blanking timeout
    scan({P8, P8, P8, P8, P8, P8});
    check_chars("t5a", 48'h383838383838);
    check1("t5a.blank", blank, 1'b0);
    fv0 = fv_cnt;
    sel = 6'h3F;
    tick(BlankTo - 100);
    check1("t5.blank_early", blank, 1'b0);
    tick(200);
    check1("t5.blank", blank, 1'b1);
    check_chars("t5b", 48'h0);
    check_int("t5.fv_none", fv_cnt, fv0);
    drive_digit(0, P1, Hold);
    check1("t5.unblank", blank, 1'b0);
    check_chars("t5c", 48'h0);
    check_int("t5.fv_partial", fv_cnt, fv0);

    // 6: reset discards a partial frame (digits 0,2,3,4 pending)
    drive_digit(2, P1, Hold);
    drive_digit(3, P1, Hold);
    drive_digit(4, P1, Hold);
    check_int("t6.fv_pre", fv_cnt, fv0);
    sel = 6'h3F;
    led = 8'hFF;
    tick(2);
    rst = 1'b1;
    tick(2);
    check_chars("t6.reset", 48'h0);
    check1("t6.reset.blank", blank, 1'b1);
    check1("t6.reset.derr", derr, 1'b0);
    rst = 1'b0;
    tick(3);
    drive_digit(1, P9, Hold);
    drive_digit(5, P9, Hold);
    check_int("t6.fv_after_two", fv_cnt, fv0);
    check_chars("t6.held", 48'h0);
    drive_digit(0, P9, Hold);
    drive_digit(2, P9, Hold);
    drive_digit(3, P9, Hold);
    check_int("t6.fv_after_five", fv_cnt, fv0);
    drive_digit(4, P9, Hold);
    check_int("t6.fv_count", fv_cnt, fv0 + 1);
    check_chars("t6", 48'h393939393939);
    check1("t6.derr", derr, 1'b0);

    check_int("fv_back_to_back", fv_dbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
